// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative unsigned multiply/divide with HI/LO registers and pipeline stall.
module mult_div_unit #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [3:0] MULTU = 4'd7, DIVU = 4'd8, MFHI = 4'd9, MFLO = 4'd10;
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_opb, r_hi, r_lo;
    logic               r_done;
    logic               w_mul_go, w_div_go, w_div0, w_last;
    logic [WIDTH:0]     w_sum, w_trial;
    assign w_mul_go = r_state == IDLE && valid && alu_ctrl == MULTU;
    assign w_div_go = r_state == IDLE && valid && alu_ctrl == DIVU && b != '0;
    assign w_div0   = r_state == IDLE && valid && alu_ctrl == DIVU && b == '0;
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    // MUL: r_acc = {partial product, remaining multiplier}; DIV: r_acc = {remainder, quotient}
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_trial  = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
    always_comb begin
        w_acc_nxt   = r_state == MUL ? {w_sum, r_acc[WIDTH-1:1]} :
                      w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0} :
                                       {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        w_state_nxt = r_state == IDLE ? (w_mul_go ? MUL : w_div_go ? DIV : IDLE) :
                      w_last ? IDLE : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opb   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_div0 || (r_state != IDLE && w_last);
            if (w_mul_go) begin
                r_acc <= {{WIDTH{1'b0}}, b};
                r_opb <= a;
                r_cnt <= '0;
            end else if (w_div_go) begin
                r_acc <= {{WIDTH{1'b0}}, a};
                r_opb <= b;
                r_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_div0) begin
                r_hi <= a;
                r_lo <= DIV0_LO;
            end else if (r_state != IDLE && w_last) begin
                r_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
                r_lo <= w_acc_nxt[WIDTH-1:0];
            end
        end
    end
    assign busy    = r_state != IDLE;
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign stall   = busy && valid && (alu_ctrl == MULTU || alu_ctrl == DIVU ||
                                       alu_ctrl == MFHI || alu_ctrl == MFLO);
    assign rd_data = alu_ctrl == MFHI ? r_hi : alu_ctrl == MFLO ? r_lo : '0;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic model.
module tb_mult_div_unit;
    logic        clk, rst, valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] a, b, rd_data, hi, lo;
    logic        stall, busy, done;
    int          errors = 0, checks = 0;
    logic [31:0] m_hi, m_lo;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .valid(valid), .alu_ctrl(alu_ctrl), .a(a), .b(b),
        .rd_data(rd_data), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        if (op == 4'd7) begin
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
        end else begin
            eh = x % y;
            el = x / y;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        alu_ctrl = op;
        valid    = 1'b1;
        a        = x;
        b        = y;
        tick();
        valid    = 1'b0;
        alu_ctrl = 4'd0;
        a        = $urandom;
        b        = $urandom;
    endtask

    // Wait out a multi-cycle op; hold=1 keeps the current (stalled) instruction on the inputs.
    task automatic finish_op(input logic [31:0] eh, input logic [31:0] el, input bit hold);
        int n = 0;
        logic [3:0] c;
        chk("busy_after_start", busy, 1);
        while (busy && n < 40) begin
            if (hold) begin
                chk("stall_held", stall, 1);
            end else begin
                c        = 4'($urandom_range(0, 15));
                valid    = 1'($urandom);
                alu_ctrl = c;
                a        = $urandom;
                b        = $urandom;
                #1;
                chk("stall_busy", stall, valid && c >= 4'd7 && c <= 4'd10);
                chk("rd_busy", rd_data, c == 4'd9 ? m_hi : c == 4'd10 ? m_lo : 32'd0);
            end
            chk("hi_hold", hi, m_hi);
            chk("lo_hold", lo, m_lo);
            tick();
            n++;
        end
        chk("busy_cycles", n, 32);
        chk("done_pulse", done, 1);
        chk("hi_result", hi, eh);
        chk("lo_result", lo, el);
        m_hi = eh;
        m_lo = el;
        if (!hold) begin
            valid    = 1'b1;
            alu_ctrl = 4'd10;
            #1;
            chk("mflo_done", rd_data, el);
            chk("mflo_stall", stall, 0);
            alu_ctrl = 4'd9;
            #1;
            chk("mfhi_done", rd_data, eh);
            valid    = 1'b0;
            alu_ctrl = 4'd0;
            tick();
            chk("done_drop", done, 0);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        model(op, x, y, eh, el);
        issue(op, x, y);
        if (op == 4'd8 && y == 0) begin
            chk("div0_busy", busy, 0);
            chk("div0_done", done, 1);
            chk("div0_hi", hi, eh);
            chk("div0_lo", lo, el);
            m_hi = eh;
            m_lo = el;
            tick();
            chk("div0_done_drop", done, 0);
            chk("div0_busy_after", busy, 0);
        end else begin
            finish_op(eh, el, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] eh, el, x, y;
        logic [3:0]  op;
        rst = 1'b1; valid = 1'b0; alu_ctrl = 4'd0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        rst = 1'b0;
        valid = 1'b1; alu_ctrl = 4'd9;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_stall", stall, 0);
        valid = 1'b0; alu_ctrl = 4'd0;
        tick();

        run_op(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_max_hi", m_hi, 32'hFFFF_FFFE);
        chk("mul_max_lo", m_lo, 32'h0000_0001);
        run_op(4'd8, 32'd100, 32'd7);
        chk("div_100_7_lo", lo, 32'd14);
        run_op(4'd8, 32'h1234_5678, 32'd0);
        run_op(4'd7, 32'd3, 32'd5);
        chk("mul_3_5_lo", lo, 32'd15);

        // Reset in the middle of an operation discards it.
        run_op(4'd7, 32'd6, 32'd7);
        issue(4'd7, $urandom, $urandom);
        repeat (9) tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        m_hi = '0; m_lo = '0;
        run_op(4'd7, 32'd2, 32'd2);

        // MULTU held while DIVU busy: accepted in the done cycle.
        issue(4'd8, 32'd9, 32'd3);
        valid = 1'b1; alu_ctrl = 4'd7; a = 32'd5; b = 32'd6;
        finish_op(32'd0, 32'd3, 1'b1);
        tick();
        valid = 1'b0; alu_ctrl = 4'd0;
        chk("chain_done_drop", done, 0);
        finish_op(32'd0, 32'd30, 1'b0);

        // Unknown codes never start an operation.
        valid = 1'b1; alu_ctrl = 4'd12;
        tick();
        valid = 1'b0; alu_ctrl = 4'd0;
        chk("bad_code_busy", busy, 0);
        chk("bad_code_done", done, 0);

        for (int i = 0; i < 25; i++) begin
            op = $urandom_range(0, 1) ? 4'd7 : 4'd8;
            x  = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            if (op == 4'd7 && y == 0) y = 32'd1;
            run_op(op, x, y);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative unsigned multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the control unit and beside the ALU in the datapath.
- Consumes the 4-bit ALU control code (MULTU=7, DIVU=8, MFHI=9, MFLO=10) plus the two register-file read operands.
- Produces HI/LO read data and a stall that holds PC and register-file writes while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; the counter is $clog2(WIDTH)+1 bits.
- DIV0_LO, 32'hFFFF_FFFF, value written to LO on divide-by-zero.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- valid  input  1  decoded instruction present this cycle.
- alu_ctrl  input  4  ALU control code from the control unit.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- rd_data  output  WIDTH  HI for MFHI, LO for MFLO, else 0; combinational.
- stall  output  1  freeze PC and RF write this cycle; combinational.
- busy  output  1  operation in flight; registered.
- done  output  1  one-cycle pulse when HI/LO are updated; registered.
- hi  output  WIDTH  HI register (debug/observe).
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and all internal shift and accumulator registers=0. Reset mid-operation aborts and discards the result; HI/LO read 0.
- States:
  - IDLE: the only state accepting a start.
  - MUL: shift-add multiply, one bit per cycle.
  - DIV: restoring divide, one bit per cycle.
- Start condition (IDLE only): valid=1 and alu_ctrl is MULTU or DIVU.
  - At start edge E0: latch a and b, set counter=0, busy=1.
  - Go to MUL or DIV.
- DIVU with b==0 at E0:
  - Do not enter DIV.
  - At E0 write HI=a, LO=DIV0_LO, done=1, busy stays 0.
  - Result is available the next cycle.
- MUL at edges E1..E32:
  - If multiplier LSB=1, add multiplicand to the upper half of a 2*WIDTH accumulator, with carry kept.
  - Shift the accumulator right by 1; counter+1.
- DIV at edges E1..E32:
  - Shift the {rem,quot} pair left by 1.
  - Trial-subtract the divisor from rem using a WIDTH+1-bit subtract.
  - If non-negative: keep the difference and set the quotient LSB=1.
  - Counter+1.
- Completion at E32 (counter reaches WIDTH-1 and finishes its final iteration):
  - MULTU: HI=product[63:32], LO=product[31:0].
  - DIVU: HI=remainder, LO=quotient.
  - busy=0, done=1 for exactly one cycle, state=IDLE.
  - busy is high for exactly WIDTH cycles.
- HI/LO change only at completion, on a divide-by-zero write, or on reset. They hold their values otherwise.
- stall = busy & valid & (alu_ctrl in {MULTU, DIVU, MFHI, MFLO}).
  - Other instructions proceed while busy; there is no stall for ALU/LW/SW/branch.
- A MULTU/DIVU arriving while busy is stalled, not accepted. It is accepted in the first cycle busy=0, which may be the same cycle done=1.
- rd_data = HI when alu_ctrl==MFHI, LO when alu_ctrl==MFLO, otherwise 0.
  - rd_data is meaningful only when stall=0.
  - In the done=1 cycle it reflects the new HI/LO.
- Any alu_ctrl code other than 7..10 is ignored, including Z/X don't-care codes. Such a code never starts an operation and never stalls.
- Operands a/b may change after E0 without affecting the result.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> busy=1 for 32 cycles, done pulse one cycle, HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- DIVU a=100, b=7 -> after 32 busy cycles HI=2, LO=14; then MFLO gives rd_data=14 and MFHI gives rd_data=2, each with stall=0.
- DIVU a=32'h1234_5678, b=0 -> next cycle HI=32'h1234_5678, LO=32'hFFFF_FFFF, done=1, busy never asserted.
- MULTU 3*5 immediately followed by MFLO held valid -> stall=1 for all 32 busy cycles, then stall=0 with rd_data=15; an ADD issued mid-operation shows stall=0.
- MULTU 6*7 complete (LO=42), then a new MULTU, with rst=1 at busy cycle 10 -> next cycle busy=0, done=0, HI=LO=0; a following MULTU 2*2 yields LO=4.
- MULTU issued while busy with DIVU 9/3 -> second op stalled until done; DIVU result (LO=3, HI=0) is written first, then MULTU starts in the done cycle and finishes 32 cycles later.
